// File: rtl/cp0_ext_if.sv
// Bus bundle between the pipeline commit stage and the CP0 block (cp0_ext).
// The pipeline side uses the master modport, the coprocessor the slave modport.
interface cp0_ext_if #(
  parameter int NUM_HW_INT = 6
);
  logic                  we_i;
  logic [4:0]            waddr_i;
  logic [4:0]            raddr_i;
  logic [31:0]           data_i;
  logic [NUM_HW_INT-1:0] int_i;
  logic                  exc_valid_i;
  logic [4:0]            exc_code_i;
  logic                  eret_i;
  logic [31:0]           pc_i;
  logic                  is_in_delayslot_i;
  logic [31:0]           bad_addr_i;
  logic [31:0]           data_o;
  logic [31:0]           status_o;
  logic [31:0]           cause_o;
  logic [31:0]           epc_o;
  logic                  int_pending_o;
  logic                  flush_o;
  logic [31:0]           newpc_o;
  logic                  timer_int_o;

  modport master (
    output we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i,
           eret_i, pc_i, is_in_delayslot_i, bad_addr_i,
    input  data_o, status_o, cause_o, epc_o, int_pending_o, flush_o,
           newpc_o, timer_int_o
  );

  modport slave (
    input  we_i, waddr_i, raddr_i, data_i, int_i, exc_valid_i, exc_code_i,
           eret_i, pc_i, is_in_delayslot_i, bad_addr_i,
    output data_o, status_o, cause_o, epc_o, int_pending_o, flush_o,
           newpc_o, timer_int_o
  );
endinterface

// File: rtl/cp0_ext.sv
// MIPS-style CP0: Status/Cause/EPC/BadVAddr, exception and ERET commit, interrupt request.
// Count/Compare timer is built only when macro CP0_TIMER_EN is defined; otherwise it reads 0.
module cp0_ext #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VALUE = 32'h004C0102
) (
  input logic      clk,
  input logic      rst,
  cp0_ext_if.slave bus
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  REG_PRID     = 5'd15;
  localparam logic [4:0]  REG_CONFIG   = 5'd16;
  localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
  localparam logic [31:0] STATUS_RESET = 32'h10400000;
  localparam logic [31:0] CONFIG_VALUE = 32'h00008000;
  localparam int          EXL_BIT      = 1;
  localparam int          IE_BIT       = 0;

  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timer;
  logic [5:0]  w_hw_int;
  logic        w_bad_addr_exc;

  always_comb begin
    w_hw_int                   = '0;
    w_hw_int[NUM_HW_INT-1:0]   = bus.int_i;
  end

`ifdef CP0_TIMER_EN
  localparam int             PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [31:0]   r_count;
  logic [31:0]   r_compare;
  logic          r_timer_int;
  logic          w_count_we;
  logic          w_compare_we;

  assign w_count_we   = bus.we_i && (bus.waddr_i == REG_COUNT);
  assign w_compare_we = bus.we_i && (bus.waddr_i == REG_COMPARE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc     <= '0;
      r_count     <= '0;
      r_compare   <= '0;
      r_timer_int <= 1'b0;
    end else begin
      if (w_count_we) begin
        r_count <= bus.data_i;
        r_presc <= '0;
      end else if (r_presc == PRESC_LAST) begin
        r_count <= r_count + 32'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      // A Compare write acknowledges the timer and beats a match in the same cycle.
      if (w_compare_we) begin
        r_compare   <= bus.data_i;
        r_timer_int <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign w_count   = r_count;
  assign w_compare = r_compare;
  assign w_timer   = r_timer_int;
`else
  assign w_count   = '0;
  assign w_compare = '0;
  assign w_timer   = 1'b0;
`endif

  assign w_bad_addr_exc = (bus.exc_code_i == 5'd4) || (bus.exc_code_i == 5'd5);

  // Later assignments in this block override earlier ones: MTC0 first, then exception/ERET.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status   <= STATUS_RESET;
      r_cause    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_cause[15:10] <= w_hw_int | {w_timer, 5'b0};
      r_cause[30]    <= w_timer;

      if (bus.we_i) begin
        case (bus.waddr_i)
          REG_STATUS: r_status <= (r_status & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
          REG_CAUSE: begin
            r_cause[9:8]   <= bus.data_i[9:8];
            r_cause[23:22] <= bus.data_i[23:22];
          end
          REG_EPC:    r_epc <= bus.data_i;
          default:    ;
        endcase
      end

      if (bus.exc_valid_i) begin
        if (!r_status[EXL_BIT]) begin
          r_epc       <= bus.is_in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
          r_cause[31] <= bus.is_in_delayslot_i;
        end
        r_cause[6:2]      <= bus.exc_code_i;
        r_status[EXL_BIT] <= 1'b1;
        if (w_bad_addr_exc) begin
          r_badvaddr <= bus.bad_addr_i;
        end
      end else if (bus.eret_i) begin
        r_status[EXL_BIT] <= 1'b0;
      end
    end
  end

  // NOTE: default assigned first so no path through this block can infer a latch.
  always_comb begin
    bus.data_o = '0;
    case (bus.raddr_i)
      REG_BADVADDR: bus.data_o = r_badvaddr;
      REG_COUNT:    bus.data_o = w_count;
      REG_COMPARE:  bus.data_o = w_compare;
      REG_STATUS:   bus.data_o = r_status;
      REG_CAUSE:    bus.data_o = r_cause;
      REG_EPC:      bus.data_o = r_epc;
      REG_PRID:     bus.data_o = PRID_VALUE;
      REG_CONFIG:   bus.data_o = CONFIG_VALUE;
      default:      bus.data_o = '0;
    endcase
  end

  always_comb begin
    bus.newpc_o = '0;
    if (bus.exc_valid_i) begin
      bus.newpc_o = EXC_VECTOR;
    end else if (bus.eret_i) begin
      bus.newpc_o = r_epc;
    end
  end

  assign bus.status_o      = r_status;
  assign bus.cause_o       = r_cause;
  assign bus.epc_o         = r_epc;
  assign bus.timer_int_o   = w_timer;
  assign bus.flush_o       = bus.exc_valid_i | bus.eret_i;
  assign bus.int_pending_o = r_status[IE_BIT] & ~r_status[EXL_BIT]
                           & (|(r_cause[15:8] & r_status[15:8]));

endmodule

// File: tb/tb_cp0_ext.sv
// Scoreboard bench for cp0_ext: driver pushes model predictions, negedge monitor compares.
// Works in both builds; the model follows CP0_TIMER_EN like the design.
module tb_cp0_ext;

  localparam int          NUM_HW_INT = 6;
  localparam int          COUNT_DIV  = 2;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [31:0] PRID_VALUE = 32'h004C0102;
`ifdef CP0_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic [4:0]  raddr;
    logic [5:0]  irq;
    logic        exc;
    logic [4:0]  code;
    logic        eret;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
  } stim_t;

  typedef struct {
    logic [4:0]  raddr;
    logic [31:0] data;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] newpc;
    logic        int_pending;
    logic        flush;
    logic        timer;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cp0_ext_if #(.NUM_HW_INT(NUM_HW_INT)) bus();

  cp0_ext #(
    .NUM_HW_INT(NUM_HW_INT),
    .COUNT_DIV (COUNT_DIV),
    .EXC_VECTOR(EXC_VECTOR),
    .PRID_VALUE(PRID_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Reference model state, kept as named architectural fields.
  logic [31:0] m_status, m_epc, m_badv, m_compare, m_base;
  int unsigned m_edges;
  logic        m_timer, m_bd, m_ti;
  logic [5:0]  m_ip_hw;
  logic [1:0]  m_ip_sw, m_c2322;
  logic [4:0]  m_exc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_status  = 32'h10400000;
    m_epc     = '0;
    m_badv    = '0;
    m_compare = '0;
    m_base    = '0;
    m_edges   = 0;
    m_timer   = 1'b0;
    m_bd      = 1'b0;
    m_ti      = 1'b0;
    m_ip_hw   = '0;
    m_ip_sw   = '0;
    m_c2322   = '0;
    m_exc     = '0;
  endfunction

  // Count is the last loaded value plus elapsed edges divided by the prescale ratio.
  function automatic logic [31:0] m_count();
    return TIMER_ON ? (m_base + 32'(m_edges / COUNT_DIV)) : 32'd0;
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 6'b0, m_c2322, 6'b0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return TIMER_ON ? m_compare : 32'd0;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID_VALUE;
      5'd16:   return 32'h00008000;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_step(input stim_t s);
    logic [31:0] cnt;
    logic        old_exl, old_timer;
    logic [5:0]  hw_mask;
    cnt       = m_count();
    old_exl   = m_status[1];
    old_timer = m_timer;
    hw_mask   = 6'((1 << NUM_HW_INT) - 1);
    m_ip_hw   = (s.irq & hw_mask) | {old_timer, 5'b0};
    m_ti      = old_timer;
    if (TIMER_ON) begin
      if (s.we && s.waddr == 5'd11) begin
        m_compare = s.data;
        m_timer   = 1'b0;
      end else if (cnt == m_compare && m_compare != 0) begin
        m_timer = 1'b1;
      end
      if (s.we && s.waddr == 5'd9) begin
        m_base  = s.data;
        m_edges = 0;
      end else begin
        m_edges++;
      end
    end
    if (s.we) begin
      case (s.waddr)
        5'd12: m_status = (m_status & ~32'h0000FF03) | (s.data & 32'h0000FF03);
        5'd13: begin
          m_ip_sw = s.data[9:8];
          m_c2322 = s.data[23:22];
        end
        5'd14: m_epc = s.data;
        default: ;
      endcase
    end
    if (s.exc) begin
      if (!old_exl) begin
        m_epc = s.ds ? s.pc - 32'd4 : s.pc;
        m_bd  = s.ds;
      end
      m_exc       = s.code;
      m_status[1] = 1'b1;
      if (s.code == 5'd4 || s.code == 5'd5) m_badv = s.bad;
    end else if (s.eret) begin
      m_status[1] = 1'b0;
    end
  endfunction

  function automatic stim_t idle(input logic [4:0] raddr);
    stim_t s;
    s = '{we: 1'b0, waddr: 5'd0, data: 32'd0, raddr: raddr, irq: 6'd0, exc: 1'b0,
          code: 5'd0, eret: 1'b0, pc: 32'd0, ds: 1'b0, bad: 32'd0};
    return s;
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom % 10)
      0: return 5'd8;
      1: return 5'd9;
      2: return 5'd11;
      3: return 5'd12;
      4: return 5'd13;
      5: return 5'd14;
      6: return 5'd15;
      7: return 5'd16;
      default: return 5'($urandom);
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.we    = ($urandom % 4) == 0;
    s.waddr = pick_reg();
    s.data  = $urandom;
    if (s.waddr == 5'd11 && ($urandom % 2) == 1) s.data = m_count() + $urandom_range(0, 8);
    s.raddr = pick_reg();
    s.irq   = 6'($urandom);
    s.exc   = ($urandom % 10) == 0;
    s.code  = (($urandom % 3) == 0) ? 5'(4 + ($urandom % 2)) : 5'($urandom);
    s.eret  = ($urandom % 8) == 0;
    s.pc    = $urandom & 32'hFFFFFFFC;
    s.ds    = 1'($urandom);
    s.bad   = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    bus.we_i              = s.we;
    bus.waddr_i           = s.waddr;
    bus.data_i            = s.data;
    bus.raddr_i           = s.raddr;
    bus.int_i             = s.irq[NUM_HW_INT-1:0];
    bus.exc_valid_i       = s.exc;
    bus.exc_code_i        = s.code;
    bus.eret_i            = s.eret;
    bus.pc_i              = s.pc;
    bus.is_in_delayslot_i = s.ds;
    bus.bad_addr_i        = s.bad;
  endtask

  // One clock: drive, predict this cycle's outputs, advance the model across the edge.
  task automatic cycle(input stim_t s);
    exp_t e;
    logic [31:0] c;
    drive(s);
    c             = m_cause();
    e.raddr       = s.raddr;
    e.data        = m_read(s.raddr);
    e.status      = m_status;
    e.cause       = c;
    e.epc         = m_epc;
    e.timer       = m_timer;
    e.flush       = s.exc | s.eret;
    e.newpc       = s.exc ? EXC_VECTOR : (s.eret ? m_epc : 32'd0);
    e.int_pending = m_status[0] & ~m_status[1] & (|(c[15:8] & m_status[15:8]));
    sb_q.push_back(e);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset between edges; outputs are checked before any clock arrives.
  task automatic async_reset();
    drive(idle(5'd12));
    rst = 1'b0;
    #1;
    check("rst_status", bus.status_o, 32'h10400000);
    check("rst_cause", bus.cause_o, 32'd0);
    check("rst_epc", bus.epc_o, 32'd0);
    check("rst_timer", {31'd0, bus.timer_int_o}, 32'd0);
    check("rst_int_pending", {31'd0, bus.int_pending_o}, 32'd0);
    check("rst_data_status", bus.data_o, 32'h10400000);
    bus.raddr_i = 5'd9;
    #0.1;
    check("rst_count", bus.data_o, 32'd0);
    model_reset();
    #0.9;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check($sformatf("data_o[r%0d]", e.raddr), bus.data_o, e.data);
      check("status_o", bus.status_o, e.status);
      check("cause_o", bus.cause_o, e.cause);
      check("epc_o", bus.epc_o, e.epc);
      check("newpc_o", bus.newpc_o, e.newpc);
      check("flush_o", {31'd0, bus.flush_o}, {31'd0, e.flush});
      check("int_pending_o", {31'd0, bus.int_pending_o}, {31'd0, e.int_pending});
      check("timer_int_o", {31'd0, bus.timer_int_o}, {31'd0, e.timer});
    end
  end

  initial begin
    stim_t s;
    int    guard;
    drive(idle(5'd12));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    async_reset();

    // Reset values visible through the read port.
    for (int r = 8; r <= 16; r++) cycle(idle(5'(r)));

    // Timer: Compare=5 written at Count=0, then rewritten to clear.
    async_reset();
    s = idle(5'd9); s.we = 1'b1; s.waddr = 5'd11; s.data = 32'd5;
    cycle(s);
    repeat (14) cycle(idle(5'd9));
    s = idle(5'd11); s.we = 1'b1; s.waddr = 5'd11; s.data = 32'd0;
    cycle(s);
    repeat (3) cycle(idle(5'd13));

    // Delay-slot exception.
    s = idle(5'd14); s.exc = 1'b1; s.code = 5'd8; s.pc = 32'hBFC00104; s.ds = 1'b1;
    cycle(s);
    cycle(idle(5'd14));
    cycle(idle(5'd13));

    // Nested exception while EXL=1.
    s = idle(5'd8); s.exc = 1'b1; s.code = 5'd5; s.pc = 32'h80001000; s.bad = 32'h80000003;
    cycle(s);
    cycle(idle(5'd8));
    cycle(idle(5'd14));

    // Interrupt enabled, masked by exception, reopened by ERET.
    s = idle(5'd12); s.irq = 6'd1; s.we = 1'b1; s.waddr = 5'd12; s.data = 32'h00000401;
    cycle(s);
    s = idle(5'd13); s.irq = 6'd1;
    repeat (2) cycle(s);
    s.exc = 1'b1; s.code = 5'd0; s.pc = 32'h00400020;
    cycle(s);
    s = idle(5'd12); s.irq = 6'd1;
    cycle(s);
    s.eret = 1'b1;
    cycle(s);
    s.eret = 1'b0;
    repeat (2) cycle(s);

    // Exception and ERET together: exception wins.
    s = idle(5'd12); s.exc = 1'b1; s.eret = 1'b1; s.code = 5'd4; s.pc = 32'h00400040;
    s.bad = 32'h12345677;
    cycle(s);
    cycle(idle(5'd8));

    // Randomized traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) async_reset();
      cycle(rand_stim());
    end
    drive(idle(5'd0));

    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
